// File: rtl/ir_decoder.sv
// NEC IR frame receiver: measures mark/space widths in prescaled ticks, validates the
// leader, 32 data bits and stop mark, and hands the frame out on valid/ready.
// Define IR_DECODER_REPEAT_EN to accept the 2.25 ms repeat code and pulse rpt.
module ir_decoder #(
   parameter int TICK_DIV = 250,
   parameter int LEAD_MIN = 800,
   parameter int LEAD_MAX = 1000,
   parameter int HDR_MIN  = 400,
   parameter int HDR_MAX  = 500,
   parameter int BIT_MIN  = 40,
   parameter int BIT_MAX  = 75,
   parameter int ONE_MIN  = 140,
   parameter int ONE_MAX  = 200,
   parameter bit INVERT   = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ir_in,
   output logic [31:0] cmd,
   output logic        valid,
   input  logic        ready,
   output logic        err,
   output logic        overrun,
   output logic        busy,
   output logic        rpt
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LEAD_MARK  = 3'd1;
   localparam logic [2:0] S_LEAD_SPACE = 3'd2;
   localparam logic [2:0] S_BIT_MARK   = 3'd3;
   localparam logic [2:0] S_BIT_SPACE  = 3'd4;
   localparam logic [2:0] S_STOP_MARK  = 3'd5;

   localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [10:0] W_SAT    = 11'h7FF;

`ifdef IR_DECODER_REPEAT_EN
   localparam int REP_MIN = 180;
   localparam int REP_MAX = 270;
`endif

   function automatic logic in_rng(input logic [10:0] w, input int lo, input int hi);
      return (int'(w) >= lo) && (int'(w) <= hi);
   endfunction

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          lvl_q, lvl_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [10:0]   width_q, width_d;
   logic [2:0]    state_q, state_d;
   logic [4:0]    idx_q, idx_d;
   logic [31:0]   sh_q, sh_d;
   logic [31:0]   cmd_q, cmd_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;
   logic          err_q, err_d;

   logic          lvl;
   logic          lvl_edge;
   logic          tick;
   logic [10:0]   meas;
   logic          fail;
   logic          done;

`ifdef IR_DECODER_REPEAT_EN
   logic          rep_q, rep_d;
   logic          rpt_q, rpt_d;
`endif

   assign lvl      = sync2_q ^ INVERT;
   assign lvl_edge = lvl ^ lvl_q;
   assign tick     = (pre_q == PRE_LAST);
   // meas is the width including the current cycle, so an edge sees the whole interval
   assign meas     = (tick && width_q != W_SAT) ? width_q + 11'd1 : width_q;

   always_comb begin
      sync1_d = ir_in;
      sync2_d = sync1_q;
      lvl_d   = lvl;
      pre_d   = tick ? '0 : pre_q + 1'b1;
      width_d = meas;
      if (lvl_edge) begin
         pre_d   = '0;
         width_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      fail    = 1'b0;
      done    = 1'b0;
`ifdef IR_DECODER_REPEAT_EN
      rep_d   = rep_q;
      rpt_d   = 1'b0;
`endif
      if (state_q == S_IDLE) begin
         if (lvl_edge && lvl) state_d = S_LEAD_MARK;
      end else if (lvl_edge) begin
         case (state_q)
            S_LEAD_MARK: begin
               if (in_rng(meas, LEAD_MIN, LEAD_MAX)) state_d = S_LEAD_SPACE;
               else fail = 1'b1;
            end
            S_LEAD_SPACE: begin
               if (in_rng(meas, HDR_MIN, HDR_MAX)) begin
                  state_d = S_BIT_MARK;
                  idx_d   = 5'd0;
`ifdef IR_DECODER_REPEAT_EN
                  rep_d   = 1'b0;
               end else if (in_rng(meas, REP_MIN, REP_MAX)) begin
                  state_d = S_STOP_MARK;
                  rep_d   = 1'b1;
`endif
               end else begin
                  fail = 1'b1;
               end
            end
            S_BIT_MARK: begin
               if (in_rng(meas, BIT_MIN, BIT_MAX)) state_d = S_BIT_SPACE;
               else fail = 1'b1;
            end
            S_BIT_SPACE: begin
               if (in_rng(meas, BIT_MIN, BIT_MAX) || in_rng(meas, ONE_MIN, ONE_MAX)) begin
                  // LSB arrives first: shift right so bit 0 ends up as the first bit on air
                  sh_d    = {in_rng(meas, ONE_MIN, ONE_MAX), sh_q[31:1]};
                  idx_d   = idx_q + 5'd1;
                  state_d = (idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
               end else begin
                  fail = 1'b1;
               end
            end
            S_STOP_MARK: begin
               state_d = S_IDLE;
               if (in_rng(meas, BIT_MIN, BIT_MAX)) begin
`ifdef IR_DECODER_REPEAT_EN
                  if (rep_q) rpt_d = 1'b1;
                  else done = 1'b1;
`else
                  done = 1'b1;
`endif
               end else begin
                  fail = 1'b1;
               end
            end
            default: fail = 1'b1;
         endcase
      end else if (meas == W_SAT) begin
         fail = 1'b1;
      end
      if (fail) state_d = S_IDLE;
      err_d = fail;
   end

   always_comb begin
      cmd_d     = cmd_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (valid_q && ready) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (done) begin
         if (!valid_q || ready) begin
            cmd_d   = sh_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= INVERT;
         sync2_q   <= INVERT;
         lvl_q     <= 1'b0;
         pre_q     <= '0;
         width_q   <= '0;
         state_q   <= S_IDLE;
         idx_q     <= '0;
         sh_q      <= '0;
         cmd_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         lvl_q     <= lvl_d;
         pre_q     <= pre_d;
         width_q   <= width_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         cmd_q     <= cmd_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         err_q     <= err_d;
      end
   end

`ifdef IR_DECODER_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= 1'b0;
         rpt_q <= 1'b0;
      end else begin
         rep_q <= rep_d;
         rpt_q <= rpt_d;
      end
   end
   assign rpt = rpt_q;
`else
   assign rpt = 1'b0;
`endif

   assign cmd     = cmd_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;
   assign err     = err_q;
   assign busy    = (state_q != S_IDLE);

endmodule
